// File: rtl/pe_dot_accum_4xpack_pkg.sv
// Shared types, lane-group geometry and latency helpers for the PE dot-product accumulator.
package pe_dot_accum_4xpack_pkg;

    // Datapath configuration shared by the multiplier and accumulator stages.
    typedef struct packed {
        int unsigned DOT_SIZE;
        int unsigned MULT_OUTPUT_WIDTH;
        int unsigned ACCUM_WIDTH;
    } pe_cfg_t;

    localparam int unsigned NUM_PACKED_FEATURES = 2;
    localparam int unsigned NUM_PACKED_FILTERS  = 2;

    localparam pe_cfg_t PE_CFG_DEFAULT = '{
        DOT_SIZE:          32'd4,
        MULT_OUTPUT_WIDTH: 32'd7,
        ACCUM_WIDTH:       32'd24
    };

    // Number of pairwise-add levels needed to reduce n leaves (0 for a single leaf).
    function automatic int unsigned tree_depth(input int unsigned n);
        return (n <= 32'd1) ? 32'd0 : 32'($clog2(n));
    endfunction

    // Registers from product input to accumulated result: conversion + tree + accumulator.
    function automatic int unsigned dot_latency(input pe_cfg_t c);
        return tree_depth(c.DOT_SIZE) + 32'd2;
    endfunction

    localparam int unsigned DOT_LATENCY_ACCUM = dot_latency(PE_CFG_DEFAULT);

endpackage

// File: rtl/pe_dot_accum_4xpack_if.sv
// Product-beat input and framed-result output bundle of the dot accumulator.
interface pe_dot_accum_4xpack_if
    import pe_dot_accum_4xpack_pkg::*;
#(
    parameter pe_cfg_t cfg = PE_CFG_DEFAULT
);
    localparam int unsigned D  = cfg.DOT_SIZE;
    localparam int unsigned M  = cfg.MULT_OUTPUT_WIDTH;
    localparam int unsigned AW = cfg.ACCUM_WIDTH;

    logic i_valid;
    logic i_first;
    logic i_last;
    logic [NUM_PACKED_FEATURES-1:0][NUM_PACKED_FILTERS-1:0][D-1:0][M-1:0] i_mult_output;

    logic o_valid;
    logic [NUM_PACKED_FEATURES-1:0][NUM_PACKED_FILTERS-1:0][AW-1:0] o_result;

    modport master (
        output i_valid, i_first, i_last, i_mult_output,
        input  o_valid, o_result
    );

    modport slave (
        input  i_valid, i_first, i_last, i_mult_output,
        output o_valid, o_result
    );

endinterface

// File: rtl/pe_dot_accum_4xpack_adder_tree.sv
// One lane: sign-magnitude to two's-complement conversion followed by a registered
// pairwise adder tree, with valid/first/last carried alongside the data.
module pe_dot_accum_4xpack_adder_tree
    import pe_dot_accum_4xpack_pkg::*;
#(
    parameter  int unsigned N         = 4,
    parameter  int unsigned IN_WIDTH  = 7,
    localparam int unsigned T         = tree_depth(N),
    localparam int unsigned OUT_WIDTH = IN_WIDTH + T
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               valid_i,
    input  logic                               first_i,
    input  logic                               last_i,
    input  logic [N-1:0][IN_WIDTH-1:0]         lane_i,
    output logic [OUT_WIDTH-1:0]               sum_o,
    output logic                               valid_o,
    output logic                               first_o,
    output logic                               last_o
);
    // Leaves padded to a power of two; nodes kept heap-ordered (root at 0).
    localparam int unsigned P = 32'd1 << T;

    logic [OUT_WIDTH-1:0] leaf_c [P];
    logic [OUT_WIDTH-1:0] node_q [2*P-1];
    logic [2:0]           side_q [T+1];

    // Negative zero maps to 0 because -0 == 0 in two's complement.
    function automatic logic [OUT_WIDTH-1:0] sm_to_tc(input logic [IN_WIDTH-1:0] x);
        logic [OUT_WIDTH-1:0] mag;
        mag = OUT_WIDTH'(x[IN_WIDTH-2:0]);
        return x[IN_WIDTH-1] ? ((~mag) + OUT_WIDTH'(1)) : mag;
    endfunction

    for (genvar i = 0; i < P; i++) begin : g_leaf
        if (i < N) begin : g_prod
            assign leaf_c[i] = sm_to_tc(lane_i[i]);
        end else begin : g_pad
            assign leaf_c[i] = '0;
        end
    end

    // Leaves register the converted products; every internal node adds its children.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned n = 0; n < 2*P-1; n++) node_q[n] <= '0;
        end else begin
            for (int unsigned n = 0; n + 1 < P; n++) begin
                node_q[n] <= node_q[2*n+1] + node_q[2*n+2];
            end
            for (int unsigned i = 0; i < P; i++) begin
                node_q[P-1+i] <= leaf_c[i];
            end
        end
    end

    // Sideband delay line matching the conversion stage plus T tree levels.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned s = 0; s <= T; s++) side_q[s] <= '0;
        end else begin
            side_q[0] <= {valid_i, first_i, last_i};
            for (int unsigned s = 1; s <= T; s++) side_q[s] <= side_q[s-1];
        end
    end

    assign sum_o   = node_q[0];
    assign valid_o = side_q[T][2];
    assign first_o = side_q[T][1];
    assign last_o  = side_q[T][0];

endmodule

// File: rtl/pe_dot_accum_4xpack.sv
// Converts packed-multiplier products to two's complement, reduces each lane with an
// adder tree and accumulates dot beats into one framed result per feature/filter pair.
module pe_dot_accum_4xpack
    import pe_dot_accum_4xpack_pkg::*;
#(
    parameter pe_cfg_t cfg = PE_CFG_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    pe_dot_accum_4xpack_if.slave   bus
);
    localparam int unsigned NF = NUM_PACKED_FEATURES;
    localparam int unsigned NK = NUM_PACKED_FILTERS;
    localparam int unsigned D  = cfg.DOT_SIZE;
    localparam int unsigned M  = cfg.MULT_OUTPUT_WIDTH;
    localparam int unsigned T  = tree_depth(D);
    localparam int unsigned W  = M + T;
    localparam int unsigned AW = cfg.ACCUM_WIDTH;

    if (D < 1) begin : g_chk_dot
        $error("DOT_SIZE must be at least 1");
    end
    if (AW < W) begin : g_chk_acc
        $error("ACCUM_WIDTH must cover MULT_OUTPUT_WIDTH plus tree growth");
    end

    logic [NF-1:0][NK-1:0][W-1:0]  lane_sum_c;
    logic [NF*NK-1:0]              lane_valid_c;
    logic [NF*NK-1:0]              lane_first_c;
    logic [NF*NK-1:0]              lane_last_c;
    logic                          beat_valid_c;
    logic                          beat_first_c;
    logic                          beat_last_c;

    logic [NF-1:0][NK-1:0][AW-1:0] acc_q;
    logic [NF-1:0][NK-1:0][AW-1:0] acc_d;
    logic [NF-1:0][NK-1:0][AW-1:0] result_q;
    logic                          valid_q;

    for (genvar f = 0; f < NF; f++) begin : g_feat
        for (genvar k = 0; k < NK; k++) begin : g_filt
            pe_dot_accum_4xpack_adder_tree #(
                .N        (D),
                .IN_WIDTH (M)
            ) u_tree (
                .clock    (clock),
                .reset    (reset),
                .valid_i  (bus.i_valid),
                .first_i  (bus.i_first),
                .last_i   (bus.i_last),
                .lane_i   (bus.i_mult_output[f][k]),
                .sum_o    (lane_sum_c[f][k]),
                .valid_o  (lane_valid_c[f*NK+k]),
                .first_o  (lane_first_c[f*NK+k]),
                .last_o   (lane_last_c[f*NK+k])
            );
        end
    end

    // Every lane carries an identical sideband copy; reducing them lets synthesis merge the flops.
    assign beat_valid_c = &lane_valid_c;
    assign beat_first_c = &lane_first_c;
    assign beat_last_c  = &lane_last_c;

    // Next accumulator value: restart on first, otherwise wrap-around add.
    always_comb begin
        acc_d = acc_q;
        for (int unsigned f = 0; f < NF; f++) begin
            for (int unsigned k = 0; k < NK; k++) begin
                if (beat_first_c) begin
                    acc_d[f][k] = AW'($signed(lane_sum_c[f][k]));
                end else begin
                    acc_d[f][k] = acc_q[f][k] + AW'($signed(lane_sum_c[f][k]));
                end
            end
        end
    end

    // Accumulator update and result capture on the closing beat of a group.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= beat_valid_c & beat_last_c;
            if (beat_valid_c) begin
                acc_q <= acc_d;
            end
            if (beat_valid_c && beat_last_c) begin
                result_q <= acc_d;
            end
        end
    end

    assign bus.o_valid  = valid_q;
    assign bus.o_result = result_q;

endmodule

// File: tb/tb_pe_dot_accum_4xpack.sv
// Scoreboard bench for pe_dot_accum_4xpack with D=4, M=7, ACCUM_WIDTH=16.
module tb_pe_dot_accum_4xpack;
    import pe_dot_accum_4xpack_pkg::*;

    localparam pe_cfg_t TB_CFG = '{
        DOT_SIZE:          32'd4,
        MULT_OUTPUT_WIDTH: 32'd7,
        ACCUM_WIDTH:       32'd16
    };
    localparam int LAT = 4;

    typedef logic [1:0][1:0][3:0][6:0] mult_t;
    typedef logic [1:0][1:0][15:0]     res_t;
    typedef struct {
        res_t res;
        int   due;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    pe_dot_accum_4xpack_if #(.cfg(TB_CFG)) bus ();

    pe_dot_accum_4xpack #(.cfg(TB_CFG)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int   cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    res_t acc_m   = '0;
    res_t last_res = '0;

    function automatic logic [6:0] sm(input int v);
        logic [5:0] mag;
        mag = (v < 0) ? 6'(-v) : 6'(v);
        return {(v < 0), mag};
    endfunction

    function automatic int lane_sum(input mult_t m, input int fi, input int ki);
        int s;
        logic [6:0] p;
        s = 0;
        for (int d = 0; d < 4; d++) begin
            p = m[fi][ki][d];
            s += p[6] ? -int'(p[5:0]) : int'(p[5:0]);
        end
        return s;
    endfunction

    function automatic mult_t all_same(input logic [6:0] p);
        mult_t m;
        for (int fi = 0; fi < 2; fi++)
            for (int ki = 0; ki < 2; ki++)
                for (int d = 0; d < 4; d++) m[fi][ki][d] = p;
        return m;
    endfunction

    // Every lane holds the value v in its first product, zero elsewhere.
    function automatic mult_t lane_value(input int v);
        mult_t m;
        m = all_same(7'd0);
        for (int fi = 0; fi < 2; fi++)
            for (int ki = 0; ki < 2; ki++) m[fi][ki][0] = sm(v);
        return m;
    endfunction

    function automatic mult_t rand_mult();
        mult_t m;
        for (int fi = 0; fi < 2; fi++)
            for (int ki = 0; ki < 2; ki++)
                for (int d = 0; d < 4; d++) m[fi][ki][d] = 7'($urandom);
        return m;
    endfunction

    // Drive one beat and update the reference accumulators.
    task automatic beat(input logic v, input logic fb, input logic lb, input mult_t m);
        @(posedge clock);
        #1;
        bus.i_valid       = v;
        bus.i_first       = fb;
        bus.i_last        = lb;
        bus.i_mult_output = m;
        if (v) begin
            for (int fi = 0; fi < 2; fi++) begin
                for (int ki = 0; ki < 2; ki++) begin
                    acc_m[fi][ki] = (fb ? 16'd0 : acc_m[fi][ki]) + 16'(lane_sum(m, fi, ki));
                end
            end
            if (lb) exp_q.push_back('{res: acc_m, due: cyc + LAT});
        end
    endtask

    task automatic idle();
        beat(1'b0, 1'($urandom), 1'($urandom), rand_mult());
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 20) begin
            @(posedge clock);
            t++;
        end
        repeat (2) @(posedge clock);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: pop an expectation on every o_valid, otherwise check the result holds.
    always @(negedge clock) begin : mon
        exp_t e;
        if (reset) begin
            last_res = '0;
        end else if (bus.o_valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid cyc=%0d result=%h", cyc, bus.o_result);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e.due) begin
                    n_fail++;
                    $display("FAIL latency got_cyc=%0d required_cyc=%0d", cyc, e.due);
                end
                n_tests++;
                if (bus.o_result !== e.res) begin
                    n_fail++;
                    $display("FAIL result got=%h required=%h", bus.o_result, e.res);
                end
                last_res = e.res;
            end
        end else begin
            n_tests++;
            if (bus.o_result !== last_res) begin
                n_fail++;
                $display("FAIL hold got=%h required=%h", bus.o_result, last_res);
            end
        end
    end

    initial begin
        mult_t m;
        bus.i_valid       = 1'b0;
        bus.i_first       = 1'b0;
        bus.i_last        = 1'b0;
        bus.i_mult_output = '0;

        repeat (3) @(posedge clock);
        #1;
        n_tests++;
        if (bus.o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got=%b required=0", bus.o_valid);
        end
        n_tests++;
        if (bus.o_result !== '0) begin
            n_fail++;
            $display("FAIL reset_result got=%h required=0", bus.o_result);
        end
        reset = 1'b0;

        // All products +3: each lane sums to 12.
        beat(1'b1, 1'b1, 1'b1, all_same(sm(3)));
        idle();
        drain();

        // Mixed signs on lane [0][0], +1 elsewhere.
        m = all_same(sm(1));
        m[0][0][0] = sm(5);
        m[0][0][1] = sm(-5);
        m[0][0][2] = sm(63);
        m[0][0][3] = sm(-1);
        beat(1'b1, 1'b1, 1'b1, m);
        idle();
        drain();

        // Negative zero everywhere.
        beat(1'b1, 1'b1, 1'b1, all_same(7'b100_0000));
        idle();
        drain();

        // Three-beat group with idle gaps: 10 + 20 - 7.
        beat(1'b1, 1'b1, 1'b0, lane_value(10));
        idle();
        idle();
        beat(1'b1, 1'b0, 1'b0, lane_value(20));
        idle();
        idle();
        beat(1'b1, 1'b0, 1'b1, lane_value(-7));
        idle();
        drain();

        // Back-to-back single-beat groups: 100 then -50.
        m = all_same(7'd0);
        for (int fi = 0; fi < 2; fi++)
            for (int ki = 0; ki < 2; ki++) begin
                m[fi][ki][0] = sm(63);
                m[fi][ki][1] = sm(37);
            end
        beat(1'b1, 1'b1, 1'b1, m);
        beat(1'b1, 1'b1, 1'b1, lane_value(-50));
        idle();
        drain();

        // Reset in the middle of a group clears outputs at once and drops the group.
        beat(1'b1, 1'b1, 1'b0, lane_value(11));
        @(posedge clock);
        #1;
        bus.i_valid = 1'b0;
        reset = 1'b1;
        #1;
        n_tests++;
        if (bus.o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_valid got=%b required=0", bus.o_valid);
        end
        n_tests++;
        if (bus.o_result !== '0) begin
            n_fail++;
            $display("FAIL async_reset_result got=%h required=0", bus.o_result);
        end
        acc_m = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        beat(1'b1, 1'b1, 1'b1, lane_value(9));
        idle();
        drain();

        // Last without a first after reset accumulates onto zero.
        beat(1'b1, 1'b0, 1'b1, lane_value(-4));
        idle();
        drain();

        // Randomized beats and framing.
        for (int i = 0; i < 400; i++) begin
            beat(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0), rand_mult());
        end
        idle();
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
